cvxif_mem_requester: RTL and testbench

Coprocessor-side initiator of the CV-X-IF memory interface. Accepts load/store operations from the coprocessor datapath, converts them into `x_mem` requests (byte enables, lane-aligned write data, transaction id) and tracks outstanding transactions. It matches returning `x_mem_result` beats by id and produces register writeback with load-data extraction and sign extension. It sits between the coprocessor execute stage and the core's CV-X-IF memory port.

---
 rtl/cvxif_mem_requester.sv | 232 +++++++++++++++++++++++
 tb/tb_cvxif_mem_requester.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_mem_requester.sv
// CV-X-IF memory requester: turns coprocessor load/store ops into x_mem
// requests, tracks in-flight ids and builds register writeback from results.

package cvxif_mem_requester_pkg;

    localparam int unsigned PkgXlen = 32;
    localparam int unsigned PkgIdW  = 4;
    localparam int unsigned PkgBeW  = PkgXlen / 8;

    typedef struct packed {
        logic [PkgIdW-1:0]  id;
        logic [PkgXlen-1:0] addr;
        logic               we;
        logic [PkgBeW-1:0]  be;
        logic [PkgXlen-1:0] wdata;
    } x_mem_req_t;

    typedef struct packed {
        logic [PkgIdW-1:0]  id;
        logic [PkgXlen-1:0] rdata;
        logic               err;
    } x_mem_result_t;

    // Per-id bookkeeping needed to build the writeback of a returning result.
    typedef struct packed {
        logic       we;
        logic [4:0] rd;
        logic [1:0] size;
        logic       sgn;
        logic [1:0] off;
    } entry_t;

endpackage

module cvxif_mem_requester
    import cvxif_mem_requester_pkg::*;
#(
    parameter int unsigned NrOutstanding = 4,
    parameter int unsigned XLEN          = PkgXlen
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            op_valid_i,
    output logic            op_ready_o,
    input  logic            op_we_i,
    input  logic [XLEN-1:0] op_addr_i,
    input  logic [XLEN-1:0] op_wdata_i,
    input  logic [1:0]      op_size_i,
    input  logic            op_signed_i,
    input  logic [4:0]      op_rd_i,
    output logic            x_mem_valid_o,
    input  logic            x_mem_ready_i,
    output x_mem_req_t      x_mem_req_o,
    input  logic            x_mem_result_valid_i,
    input  x_mem_result_t   x_mem_result_i,
    output logic            wb_valid_o,
    output logic            wb_we_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            wb_err_o,
    output logic            busy_o,
    output logic            spurious_o
);

    localparam int unsigned IdxW = (NrOutstanding > 1) ? $clog2(NrOutstanding) : 1;
    localparam int unsigned BeW  = XLEN / 8;

    typedef logic [IdxW-1:0] idx_t;

    logic                     req_valid_q, req_valid_d;
    x_mem_req_t               req_q, req_d;
    logic [NrOutstanding-1:0] busy_q, busy_d;
    entry_t [NrOutstanding-1:0] ent_q, ent_d;
    idx_t                     alloc_ptr_q, alloc_ptr_d;
    logic                     wb_valid_q, wb_valid_d;
    logic                     wb_we_q, wb_we_d;
    logic [4:0]               wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]          wb_data_q, wb_data_d;
    logic                     wb_err_q, wb_err_d;
    logic                     spurious_q, spurious_d;

    logic            op_misaligned;
    logic            op_fire;
    logic [BeW-1:0]  be_base;
    idx_t            res_idx;
    logic            res_in_range;
    logic            res_hit;
    entry_t          res_ent;
    logic [XLEN-1:0] ld_shifted;
    logic [XLEN-1:0] ld_data;

    // Alignment check and byte-enable pattern of the incoming op.
    always_comb begin : op_decode
        op_misaligned = 1'b0;
        be_base       = '0;
        unique case (op_size_i)
            2'd0: begin
                op_misaligned = 1'b0;
                be_base       = BeW'(4'b0001);
            end
            2'd1: begin
                op_misaligned = op_addr_i[0];
                be_base       = BeW'(4'b0011);
            end
            2'd2: begin
                op_misaligned = |op_addr_i[1:0];
                be_base       = BeW'(4'b1111);
            end
            default: begin
                op_misaligned = 1'b1;
                be_base       = '0;
            end
        endcase
    end

    // Misaligned ops are held off while a result arrives so the two never share the wb register.
    assign op_ready_o = !rst_i && !req_valid_q && !busy_q[alloc_ptr_q]
                        && !(op_misaligned && x_mem_result_valid_i);
    assign op_fire    = op_valid_i && op_ready_o;

    // Result lookup; ids beyond the table size can never be in flight.
    assign res_idx      = x_mem_result_i.id[IdxW-1:0];
    assign res_in_range = (x_mem_result_i.id >> IdxW) == '0;
    assign res_hit      = x_mem_result_valid_i && res_in_range && busy_q[res_idx];
    assign res_ent      = ent_q[res_idx];

    // Load data: move the addressed lanes down, then truncate and extend to size.
    always_comb begin : load_extract
        ld_shifted = x_mem_result_i.rdata >> {res_ent.off, 3'b000};
        unique case (res_ent.size)
            2'd0: ld_data = res_ent.sgn ? {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]}
                                        : {{(XLEN-8){1'b0}}, ld_shifted[7:0]};
            2'd1: ld_data = res_ent.sgn ? {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]}
                                        : {{(XLEN-16){1'b0}}, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

    // Next-state for request register, entry table, allocation pointer and writeback.
    always_comb begin : next_state
        req_valid_d = req_valid_q;
        req_d       = req_q;
        busy_d      = busy_q;
        ent_d       = ent_q;
        alloc_ptr_d = alloc_ptr_q;
        wb_valid_d  = 1'b0;
        wb_we_d     = 1'b0;
        wb_rd_d     = '0;
        wb_data_d   = '0;
        wb_err_d    = 1'b0;
        spurious_d  = spurious_q;

        if (req_valid_q && x_mem_ready_i) begin
            req_valid_d = 1'b0;
        end

        if (x_mem_result_valid_i) begin
            if (res_hit) begin
                busy_d[res_idx] = 1'b0;
                wb_valid_d      = 1'b1;
                wb_err_d        = x_mem_result_i.err;
                wb_rd_d         = res_ent.rd;
                wb_we_d         = !res_ent.we && !x_mem_result_i.err;
                wb_data_d       = (res_ent.we || x_mem_result_i.err) ? '0 : ld_data;
            end else begin
                spurious_d = 1'b1;
            end
        end

        if (op_fire) begin
            if (op_misaligned) begin
                wb_valid_d = 1'b1;
                wb_err_d   = 1'b1;
                wb_rd_d    = op_rd_i;
            end else begin
                req_valid_d            = 1'b1;
                req_d.id               = PkgIdW'(alloc_ptr_q);
                req_d.addr             = op_addr_i;
                req_d.we               = op_we_i;
                req_d.be               = be_base << op_addr_i[1:0];
                req_d.wdata            = op_wdata_i << {op_addr_i[1:0], 3'b000};
                busy_d[alloc_ptr_q]    = 1'b1;
                ent_d[alloc_ptr_q].we   = op_we_i;
                ent_d[alloc_ptr_q].rd   = op_rd_i;
                ent_d[alloc_ptr_q].size = op_size_i;
                ent_d[alloc_ptr_q].sgn  = op_signed_i;
                ent_d[alloc_ptr_q].off  = op_addr_i[1:0];
                alloc_ptr_d            = alloc_ptr_q + idx_t'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_valid_q <= 1'b0;
            req_q       <= '0;
            busy_q      <= '0;
            ent_q       <= '0;
            alloc_ptr_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_err_q    <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            req_valid_q <= req_valid_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            ent_q       <= ent_d;
            alloc_ptr_q <= alloc_ptr_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            wb_err_q    <= wb_err_d;
            spurious_q  <= spurious_d;
        end
    end

    assign x_mem_valid_o = req_valid_q;
    assign x_mem_req_o   = req_q;
    assign wb_valid_o    = wb_valid_q;
    assign wb_we_o       = wb_we_q;
    assign wb_rd_o       = wb_rd_q;
    assign wb_data_o     = wb_data_q;
    assign wb_err_o      = wb_err_q;
    assign spurious_o    = spurious_q;
    assign busy_o        = req_valid_q || (|busy_q);

endmodule

// File: tb/tb_cvxif_mem_requester.sv
// Bench for cvxif_mem_requester: directed scenarios plus random traffic,
// all checked against a cycle-level transaction model of the requester.

module tb_cvxif_mem_requester;
    import cvxif_mem_requester_pkg::*;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          op_valid, op_ready_o, op_we, op_signed;
    logic [31:0]   op_addr, op_wdata;
    logic [1:0]    op_size;
    logic [4:0]    op_rd;
    logic          x_mem_valid_o, x_mem_ready;
    x_mem_req_t    x_mem_req_o;
    logic          res_valid;
    x_mem_result_t res;
    logic          wb_valid_o, wb_we_o, wb_err_o, busy_o, spurious_o;
    logic [4:0]    wb_rd_o;
    logic [31:0]   wb_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cvxif_mem_requester #(.NrOutstanding(NR), .XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .op_valid_i(op_valid), .op_ready_o(op_ready_o), .op_we_i(op_we),
        .op_addr_i(op_addr), .op_wdata_i(op_wdata), .op_size_i(op_size),
        .op_signed_i(op_signed), .op_rd_i(op_rd),
        .x_mem_valid_o(x_mem_valid_o), .x_mem_ready_i(x_mem_ready), .x_mem_req_o(x_mem_req_o),
        .x_mem_result_valid_i(res_valid), .x_mem_result_i(res),
        .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .wb_err_o(wb_err_o), .busy_o(busy_o), .spurious_o(spurious_o)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transaction model: pending request, per-id table, expected writeback.
    bit         m_reqv;
    x_mem_req_t m_req;
    bit         m_busy [NR];
    bit         m_issued [NR];
    bit         m_we [NR];
    logic [4:0] m_rd [NR];
    int         m_size [NR];
    bit         m_sgn [NR];
    int         m_off [NR];
    int         m_ptr;
    bit         e_wbv, e_wbwe, e_wberr, e_spur;
    logic [4:0] e_wbrd;
    logic [31:0] e_wbdata;
    bit         last_acc;

    task automatic model_reset();
        m_reqv = 0; m_req = '0; m_ptr = 0; e_spur = 0;
        e_wbv = 0; e_wbwe = 0; e_wberr = 0; e_wbrd = '0; e_wbdata = '0;
        for (int i = 0; i < NR; i++) begin
            m_busy[i] = 0; m_issued[i] = 0;
        end
    endtask

    function automatic logic [31:0] extract(logic [31:0] rdata, int off, int size, bit sgn);
        int          bits;
        logic [63:0] v;
        bits = 8 << size;
        v = 64'(rdata >> (8 * off)) & ((64'd1 << bits) - 64'd1);
        if (sgn && v[bits-1]) v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic step();
        bit mis, exp_ready, anybusy;
        int sz, off, id;
        #1;
        sz  = int'(op_size);
        off = int'(op_addr[1:0]);
        mis = (sz == 3) || (sz == 1 && off % 2 == 1) || (sz == 2 && off != 0);
        exp_ready = !rst_i && !m_reqv && !m_busy[m_ptr] && !(mis && res_valid);
        anybusy = m_reqv;
        for (int i = 0; i < NR; i++) anybusy |= m_busy[i];
        chk("op_ready", 128'(op_ready_o), 128'(exp_ready));
        chk("x_mem_valid", 128'(x_mem_valid_o), 128'(m_reqv));
        if (m_reqv) chk("x_mem_req", 128'(x_mem_req_o), 128'(m_req));
        chk("wb_valid", 128'(wb_valid_o), 128'(e_wbv));
        if (e_wbv) begin
            chk("wb_we", 128'(wb_we_o), 128'(e_wbwe));
            chk("wb_rd", 128'(wb_rd_o), 128'(e_wbrd));
            chk("wb_data", 128'(wb_data_o), 128'(e_wbdata));
            chk("wb_err", 128'(wb_err_o), 128'(e_wberr));
        end
        chk("busy", 128'(busy_o), 128'(anybusy));
        chk("spurious", 128'(spurious_o), 128'(e_spur));
        last_acc = op_valid && exp_ready;
        e_wbv = 0; e_wbwe = 0; e_wberr = 0; e_wbrd = '0; e_wbdata = '0;
        if (rst_i) begin
            model_reset();
            last_acc = 0;
        end else begin
            if (res_valid) begin
                id = int'(res.id);
                if (id < NR && m_busy[id]) begin
                    e_wbv    = 1;
                    e_wberr  = res.err;
                    e_wbrd   = m_rd[id];
                    e_wbwe   = !m_we[id] && !res.err;
                    e_wbdata = (m_we[id] || res.err) ? 32'd0
                             : extract(res.rdata, m_off[id], m_size[id], m_sgn[id]);
                    m_busy[id] = 0;
                    m_issued[id] = 0;
                end else begin
                    e_spur = 1;
                end
            end
            if (m_reqv && x_mem_ready) begin
                m_reqv = 0;
                m_issued[int'(m_req.id)] = 1;
            end
            if (last_acc) begin
                if (mis) begin
                    e_wbv = 1; e_wberr = 1; e_wbrd = op_rd;
                end else begin
                    m_reqv       = 1;
                    m_req.id     = 4'(m_ptr);
                    m_req.addr   = op_addr;
                    m_req.we     = op_we;
                    m_req.be     = 4'(((1 << (1 << sz)) - 1) << off);
                    m_req.wdata  = 32'(64'(op_wdata) << (8 * off));
                    m_busy[m_ptr] = 1;
                    m_we[m_ptr]   = op_we;
                    m_rd[m_ptr]   = op_rd;
                    m_size[m_ptr] = sz;
                    m_sgn[m_ptr]  = op_signed;
                    m_off[m_ptr]  = off;
                    m_ptr = (m_ptr + 1) % NR;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic set_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input bit sgn, input logic [4:0] rd);
        op_valid = 1; op_we = we; op_addr = addr; op_wdata = wdata;
        op_size = size; op_signed = sgn; op_rd = rd;
    endtask

    // Present an op and step until it is accepted (bounded).
    task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input bit sgn, input logic [4:0] rd);
        bit done;
        done = 0;
        set_op(we, addr, wdata, size, sgn, rd);
        for (int i = 0; i < 32 && !done; i++) begin
            step();
            done = last_acc;
        end
        if (!done) chk("accept_timeout", 128'(0), 128'(1));
        op_valid = 0;
    endtask

    task automatic give_result(input int id, input logic [31:0] rdata, input bit err);
        res_valid = 1;
        res.id = 4'(id); res.rdata = rdata; res.err = err;
        step();
        res_valid = 0;
    endtask

    x_mem_req_t saved;
    int         sid;
    int         q[$];

    initial begin
        rst_i = 1; op_valid = 0; op_we = 0; op_addr = '0; op_wdata = '0;
        op_size = '0; op_signed = 0; op_rd = '0; x_mem_ready = 1;
        res_valid = 0; res = '0;
        model_reset();
        @(negedge clk);
        step(); step();
        chk("rst_op_ready", 128'(op_ready_o), 128'(0));
        chk("rst_x_mem_valid", 128'(x_mem_valid_o), 128'(0));
        chk("rst_x_mem_req", 128'(x_mem_req_o), 128'(0));
        chk("rst_wb", 128'({wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, wb_err_o}), 128'(0));
        chk("rst_busy_spur", 128'({busy_o, spurious_o}), 128'(0));
        rst_i = 0;

        // Aligned word store.
        issue(1, 32'h1000, 32'hDEADBEEF, 2'd2, 0, 5'd1);
        chk("t1_valid", 128'(x_mem_valid_o), 128'(1));
        chk("t1_id", 128'(x_mem_req_o.id), 128'(0));
        chk("t1_be", 128'(x_mem_req_o.be), 128'(4'b1111));
        chk("t1_wdata", 128'(x_mem_req_o.wdata), 128'(32'hDEADBEEF));
        step();
        give_result(0, 32'h0, 0);
        chk("t1_wb", 128'({wb_valid_o, wb_we_o, wb_err_o}), 128'(3'b100));

        // Signed / unsigned byte loads from lane 3.
        issue(0, 32'h2003, 32'h0, 2'd0, 1, 5'd7);
        chk("t2_be", 128'(x_mem_req_o.be), 128'(4'b1000));
        step();
        give_result(1, 32'h80112233, 0);
        chk("t2_sdata", 128'(wb_data_o), 128'(32'hFFFFFF80));
        chk("t2_rd_we", 128'({wb_rd_o, wb_we_o}), 128'({5'd7, 1'b1}));
        issue(0, 32'h2003, 32'h0, 2'd0, 0, 5'd8);
        step();
        give_result(2, 32'h80112233, 0);
        chk("t2_udata", 128'(wb_data_o), 128'(32'h00000080));

        // Misaligned word load.
        issue(0, 32'h2002, 32'h0, 2'd2, 0, 5'd9);
        chk("t3_novalid", 128'(x_mem_valid_o), 128'(0));
        chk("t3_wb", 128'({wb_valid_o, wb_err_o, wb_we_o}), 128'(3'b110));

        // Fill the table, return out of order, fifth op waits for id 0.
        rst_i = 1; step(); rst_i = 0;
        for (int k = 0; k < 4; k++) issue(0, 32'h3000 + 32'(4 * k), 32'h0, 2'd2, 0, 5'(10 + k));
        step();
        set_op(0, 32'h4000, 32'h0, 2'd2, 0, 5'd20);
        for (int k = 0; k < 3; k++) step();
        chk("t4_full", 128'(op_ready_o), 128'(0));
        give_result(2, 32'h12345678, 0);
        chk("t4_rd2", 128'(wb_rd_o), 128'(5'd12));
        chk("t4_still_full", 128'(op_ready_o), 128'(0));
        give_result(0, 32'hCAFEF00D, 0);
        chk("t4_rd0", 128'(wb_rd_o), 128'(5'd10));
        chk("t4_ready", 128'(op_ready_o), 128'(1));
        step();
        chk("t4_acc", 128'(last_acc), 128'(1));
        op_valid = 0;
        chk("t4_id0", 128'(x_mem_req_o.id), 128'(0));
        step();
        give_result(1, 32'h1, 0);
        give_result(3, 32'h3, 0);
        give_result(0, 32'h0, 0);

        // Backpressure: request held stable, no acceptance.
        x_mem_ready = 0;
        issue(1, 32'h5006, 32'h0000ABCD, 2'd1, 0, 5'd0);
        chk("t5_be", 128'(x_mem_req_o.be), 128'(4'b1100));
        chk("t5_wdata", 128'(x_mem_req_o.wdata), 128'(32'hABCD0000));
        saved = m_req;
        set_op(0, 32'h5100, 32'h0, 2'd2, 0, 5'd4);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_stable", 128'(x_mem_req_o), 128'(saved));
            chk("t5_ready", 128'(op_ready_o), 128'(0));
        end
        op_valid = 0;
        x_mem_ready = 1;
        step();
        give_result(int'(saved.id), 32'h0, 0);

        // Bus error, spurious result, reset with entries in flight.
        issue(0, 32'h6000, 32'h0, 2'd2, 0, 5'd3);
        sid = int'(m_req.id);
        step();
        give_result(sid, 32'hFFFFFFFF, 1);
        chk("t6_err", 128'({wb_valid_o, wb_err_o, wb_we_o, wb_data_o}), 128'({3'b110, 32'h0}));
        give_result(3, 32'h0, 0);
        step(); step();
        chk("t6_spur", 128'(spurious_o), 128'(1));
        issue(0, 32'h7000, 32'h0, 2'd2, 0, 5'd5);
        issue(0, 32'h7004, 32'h0, 2'd2, 0, 5'd6);
        step();
        chk("t6_busy", 128'(busy_o), 128'(1));
        rst_i = 1; step(); rst_i = 0;
        chk("t6_rst_busy", 128'(busy_o), 128'(0));
        chk("t6_rst_spur", 128'(spurious_o), 128'(0));
        give_result(0, 32'h0, 0);
        chk("t6_late_spur", 128'(spurious_o), 128'(1));

        // Random traffic.
        rst_i = 1; step(); rst_i = 0;
        for (int c = 0; c < 800; c++) begin
            set_op(1'($urandom), $urandom, $urandom, 2'($urandom_range(0, 3)),
                   1'($urandom), 5'($urandom));
            op_valid = ($urandom_range(0, 2) != 0);
            x_mem_ready = ($urandom_range(0, 3) != 0);
            res_valid = 0;
            q.delete();
            for (int i = 0; i < NR; i++) if (m_issued[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                res_valid = 1;
                res.id    = 4'(q[$urandom_range(0, q.size() - 1)]);
                res.rdata = $urandom;
                res.err   = ($urandom_range(0, 7) == 0);
            end
            step();
        end
        op_valid = 0; res_valid = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
